// File: rtl/alioth_timer.sv
// Machine timer peripheral: 64-bit mtime advanced by a programmable prescaler,
// 64-bit mtimecmp with sticky pending flag and level interrupt, request/ack slave bus.
module alioth_timer #(
    parameter int ADDR_WIDTH  = 8,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o,
    output logic                  ack_o,
    output logic                  err_o,
    input  logic                  halt_i,
    output logic                  irq_o
);

    localparam int WORD_W       = ADDR_WIDTH - 2;
    localparam int NUM_REGS     = 7;
    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_MTIME_LO = 2;
    localparam int REG_MTIME_HI = 3;
    localparam int REG_CMP_LO   = 4;
    localparam int REG_CMP_HI   = 5;
    localparam int REG_PRESC    = 6;

    // Register state
    logic                   en_reg;
    logic                   auto_reload_reg;
    logic                   irq_en_reg;
    logic                   pend_reg;
    logic [63:0]            mtime_reg;
    logic [63:0]            mtimecmp_reg;
    logic [PRESC_WIDTH-1:0] presc_reg;
    logic [PRESC_WIDTH-1:0] pcnt_reg;
    logic [31:0]            rdata_reg;
    logic                   ack_reg;
    logic                   err_reg;
    logic                   irq_reg;

    // Next-state values
    logic                   en_next;
    logic                   auto_reload_next;
    logic                   irq_en_next;
    logic                   pend_next;
    logic [63:0]            mtime_next;
    logic [63:0]            mtimecmp_next;
    logic [PRESC_WIDTH-1:0] presc_next;
    logic [PRESC_WIDTH-1:0] pcnt_next;
    logic [31:0]            rdata_next;

    // Address decode
    logic [WORD_W-1:0]   word_idx;
    logic                mapped;
    logic [NUM_REGS-1:0] sel;
    logic [NUM_REGS-1:0] wr_sel;
    logic [1:0]          unused_addr_bits;

    assign word_idx         = addr_i[ADDR_WIDTH-1:2];
    assign unused_addr_bits = addr_i[1:0];
    assign mapped           = (word_idx <= WORD_W'(REG_PRESC));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign sel[gi]    = req_i & (word_idx == WORD_W'(gi));
            assign wr_sel[gi] = sel[gi] & we_i;
        end
    endgenerate

    // Tick and compare datapath
    logic        tick;
    logic [63:0] mtime_inc;
    logic        reload;
    logic        cmp_hit;
    logic        pend_clr;

    assign tick      = en_reg & ~halt_i & (pcnt_reg == presc_reg);
    assign mtime_inc = mtime_reg + 64'd1;
    assign reload    = tick & auto_reload_reg & (mtime_inc >= mtimecmp_reg);
    assign cmp_hit   = (mtime_reg >= mtimecmp_reg);
    assign pend_clr  = wr_sel[REG_STATUS] & wdata_i[0];

    always_comb begin
        pcnt_next = pcnt_reg;
        if (!en_reg) begin
            pcnt_next = '0;
        end else if (!halt_i) begin
            // Free-running compare: a PRESC written below pcnt lets pcnt wrap naturally.
            pcnt_next = tick ? '0 : pcnt_reg + 1'b1;
        end
    end

    always_comb begin
        mtime_next = mtime_reg;
        if (tick) begin
            mtime_next = reload ? 64'd0 : mtime_inc;
        end
        // A bus write overrides only its half; the other half keeps its pre-tick value.
        if (wr_sel[REG_MTIME_LO]) begin
            mtime_next[31:0]  = wdata_i;
            mtime_next[63:32] = mtime_reg[63:32];
        end
        if (wr_sel[REG_MTIME_HI]) begin
            mtime_next[63:32] = wdata_i;
            mtime_next[31:0]  = mtime_reg[31:0];
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_cmp_half
            assign mtimecmp_next[32*gi +: 32] =
                wr_sel[REG_CMP_LO + gi] ? wdata_i : mtimecmp_reg[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        en_next          = en_reg;
        auto_reload_next = auto_reload_reg;
        irq_en_next      = irq_en_reg;
        if (wr_sel[REG_CTRL]) begin
            en_next          = wdata_i[0];
            auto_reload_next = wdata_i[1];
            irq_en_next      = wdata_i[2];
        end
    end

    assign presc_next = wr_sel[REG_PRESC] ? wdata_i[PRESC_WIDTH-1:0] : presc_reg;

    // Set beats a simultaneous write-1-to-clear.
    assign pend_next = cmp_hit | reload | (pend_reg & ~pend_clr);

    always_comb begin
        rdata_next = 32'd0;
        if (req_i && !we_i && mapped) begin
            unique case (int'(word_idx))
                REG_CTRL:     rdata_next = {29'd0, irq_en_reg, auto_reload_reg, en_reg};
                REG_STATUS:   rdata_next = {31'd0, pend_reg};
                REG_MTIME_LO: rdata_next = mtime_reg[31:0];
                REG_MTIME_HI: rdata_next = mtime_reg[63:32];
                REG_CMP_LO:   rdata_next = mtimecmp_reg[31:0];
                REG_CMP_HI:   rdata_next = mtimecmp_reg[63:32];
                REG_PRESC:    rdata_next = 32'(presc_reg);
                default:      rdata_next = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_reg          <= 1'b0;
            auto_reload_reg <= 1'b0;
            irq_en_reg      <= 1'b0;
            pend_reg        <= 1'b0;
            mtime_reg       <= 64'd0;
            mtimecmp_reg    <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_reg       <= '0;
            pcnt_reg        <= '0;
            rdata_reg       <= 32'd0;
            ack_reg         <= 1'b0;
            err_reg         <= 1'b0;
            irq_reg         <= 1'b0;
        end else begin
            en_reg          <= en_next;
            auto_reload_reg <= auto_reload_next;
            irq_en_reg      <= irq_en_next;
            pend_reg        <= pend_next;
            mtime_reg       <= mtime_next;
            mtimecmp_reg    <= mtimecmp_next;
            presc_reg       <= presc_next;
            pcnt_reg        <= pcnt_next;
            rdata_reg       <= rdata_next;
            ack_reg         <= req_i;
            err_reg         <= req_i & ~mapped;
            irq_reg         <= pend_reg & irq_en_reg;
        end
    end

    assign rdata_o = rdata_reg;
    assign ack_o   = ack_reg;
    assign err_o   = err_reg;
    assign irq_o   = irq_reg;

endmodule
